// File: rtl/johnson_decoder_if.sv
// Johnson-code link bundle: code sample and qualifiers in, decoded index and
// status out. The master drives the code, the slave is the decoder.
interface johnson_decoder_if #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 3,
   parameter int ERR_W = 8
);
   logic [WIDTH-1:0] code_in;
   logic             code_valid;
   logic             err_clr;
   logic [IDX_W-1:0] index_out;
   logic             index_valid;
   logic             illegal;
   logic             seq_err;
   logic             locked;
   logic [ERR_W-1:0] err_count;

   modport master (
      output code_in, code_valid, err_clr,
      input  index_out, index_valid, illegal, seq_err, locked, err_count
   );

   modport slave (
      input  code_in, code_valid, err_clr,
      output index_out, index_valid, illegal, seq_err, locked, err_count
   );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes each valid code to its index, checks it
// against the expected successor, locks after LOCK_COUNT good steps and keeps
// a saturating count of illegal codes and sequence breaks.
module johnson_decoder #(
   parameter int WIDTH      = 4,
   parameter int IDX_W      = 3,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   johnson_decoder_if.slave  bus
);
   localparam int                CNT_W     = $clog2(LOCK_COUNT + 1);
   // Sequence length reduced modulo 2**IDX_W; subtraction below wraps correctly.
   localparam logic [IDX_W-1:0]  SEQ_LEN   = IDX_W'(2 * WIDTH);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(2 * WIDTH - 1);
   localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_COUNT - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

   typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  good_reg, good_next;
   logic [IDX_W-1:0]  prev_reg, prev_next;
   logic [IDX_W-1:0]  index_reg, index_next;
   logic              index_valid_reg, index_valid_next;
   logic              illegal_reg, illegal_next;
   logic              seq_err_reg, seq_err_next;
   logic [ERR_W-1:0]  err_reg, err_next;

   logic [WIDTH-2:0]  edge_bits;
   logic [IDX_W-1:0]  pop;
   logic [IDX_W-1:0]  n_edges;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  succ_idx;
   logic              legal;
   logic              is_succ;
   logic              err_event;

   // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
         assign edge_bits[gi] = bus.code_in[gi] ^ bus.code_in[gi+1];
      end
   endgenerate

   // Decode: popcount and boundary count, index and expected successor.
   always_comb begin
      pop     = '0;
      n_edges = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + IDX_W'(bus.code_in[i]);
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         n_edges = n_edges + IDX_W'(edge_bits[i]);
      end
      legal    = (n_edges <= IDX_W'(1));
      idx      = bus.code_in[WIDTH-1] ? (SEQ_LEN - pop) : pop;
      succ_idx = (prev_reg == LAST_IDX) ? '0 : prev_reg + 1'b1;
      is_succ  = (idx == succ_idx);
   end

   // Next-state, lock tracking and output pulses.
   always_comb begin
      state_next       = state_reg;
      good_next        = good_reg;
      prev_next        = prev_reg;
      index_next       = index_reg;
      index_valid_next = 1'b0;
      illegal_next     = 1'b0;
      seq_err_next     = 1'b0;
      err_event        = 1'b0;

      if (bus.code_valid) begin
         if (!legal) begin
            illegal_next = 1'b1;
            err_event    = 1'b1;
            state_next   = HUNT;
            good_next    = '0;
         end else begin
            index_next       = idx;
            index_valid_next = 1'b1;
            prev_next        = idx;
            unique case (state_reg)
               HUNT: begin
                  state_next = TRACK;
                  good_next  = '0;
               end
               TRACK: begin
                  if (is_succ) begin
                     if (good_reg == LOCK_LAST) begin
                        state_next = LOCKED;
                        good_next  = '0;
                     end else begin
                        good_next = good_reg + 1'b1;
                     end
                  end else begin
                     good_next = '0;
                  end
               end
               LOCKED: begin
                  if (!is_succ) begin
                     seq_err_next = 1'b1;
                     err_event    = 1'b1;
                     state_next   = HUNT;
                     good_next    = '0;
                  end
               end
               default: begin
                  state_next = HUNT;
                  good_next  = '0;
               end
            endcase
         end
      end

      // Clear wins over a simultaneous increment; count saturates.
      if (bus.err_clr) begin
         err_next = '0;
      end else if (err_event && (err_reg != ERR_MAX)) begin
         err_next = err_reg + 1'b1;
      end else begin
         err_next = err_reg;
      end
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= HUNT;
         good_reg        <= '0;
         prev_reg        <= '0;
         index_reg       <= '0;
         index_valid_reg <= 1'b0;
         illegal_reg     <= 1'b0;
         seq_err_reg     <= 1'b0;
         err_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         good_reg        <= good_next;
         prev_reg        <= prev_next;
         index_reg       <= index_next;
         index_valid_reg <= index_valid_next;
         illegal_reg     <= illegal_next;
         seq_err_reg     <= seq_err_next;
         err_reg         <= err_next;
      end
   end

   assign bus.index_out   = index_reg;
   assign bus.index_valid = index_valid_reg;
   assign bus.illegal     = illegal_reg;
   assign bus.seq_err     = seq_err_reg;
   assign bus.locked      = (state_reg == LOCKED);
   assign bus.err_count   = err_reg;
endmodule
